// File: rtl/bnn_ctrl_pkg.sv
// Shared types and default geometry for the BNN inference sequencer.
// The DEF_* constants are the default module parameters. N_IMG_BYTES and
// score_t follow those defaults.
package bnn_ctrl_pkg;

   localparam int DEF_IMG_BITS      = 784;
   localparam int DEF_BYTE_W        = 8;
   localparam int DEF_N_CLASSES     = 10;
   localparam int DEF_SCORE_W       = 7;
   localparam int DEF_CLASS_W       = 4;
   localparam int DEF_SETTLE_CYCLES = 16;

   localparam int N_IMG_BYTES = DEF_IMG_BITS / DEF_BYTE_W;
   localparam int SETTLE_W    = 8;

   typedef logic [DEF_SCORE_W-1:0] score_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_CAPTURE,
      ST_ARGMAX,
      ST_DONE
   } ctrl_state_t;

endpackage

// File: rtl/bnn_infer_ctrl_argmax.sv
// Sequential argmax over a registered array of class scores.
// A start pulse captures the scores and seeds the best candidate with class 0.
// The block then examines one class per cycle. A strict compare means ties
// keep the lowest index. done_o is high in the cycle that examines the last
// class. class_o/score_o are updated on the edge that ends that cycle and are
// held until the next result.
module bnn_argmax_seq
   import bnn_ctrl_pkg::*;
#(
   parameter int N_CLASSES = DEF_N_CLASSES,
   parameter int SCORE_W   = DEF_SCORE_W,
   parameter int CLASS_W   = DEF_CLASS_W
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [N_CLASSES*SCORE_W-1:0] scores_i,
   output logic                         done_o,
   output logic [CLASS_W-1:0]           class_o,
   output logic [SCORE_W-1:0]           score_o
);

   logic [SCORE_W-1:0] score_q [N_CLASSES];
   logic [SCORE_W-1:0] score_d [N_CLASSES];
   logic [CLASS_W-1:0] idx_q, idx_d;
   logic [CLASS_W-1:0] best_idx_q, best_idx_d;
   logic [SCORE_W-1:0] best_q, best_d;
   logic [CLASS_W-1:0] res_idx_q, res_idx_d;
   logic [SCORE_W-1:0] res_score_q, res_score_d;
   logic               run_q, run_d;

   // Capture scores on start, then walk one class per cycle updating the best
   always_comb begin
      for (int c = 0; c < N_CLASSES; c++) begin
         score_d[c] = score_q[c];
      end
      idx_d       = idx_q;
      best_idx_d  = best_idx_q;
      best_d      = best_q;
      res_idx_d   = res_idx_q;
      res_score_d = res_score_q;
      run_d       = run_q;
      done_o      = 1'b0;
      if (start_i) begin
         for (int c = 0; c < N_CLASSES; c++) begin
            score_d[c] = scores_i[c*SCORE_W +: SCORE_W];
         end
         best_idx_d = '0;
         best_d     = scores_i[SCORE_W-1:0];
         idx_d      = CLASS_W'(1);
         run_d      = 1'b1;
      end else if (run_q) begin
         if (score_q[idx_q] > best_q) begin
            best_idx_d = idx_q;
            best_d     = score_q[idx_q];
         end
         if (idx_q == CLASS_W'(N_CLASSES-1)) begin
            run_d       = 1'b0;
            done_o      = 1'b1;
            res_idx_d   = best_idx_d;
            res_score_d = best_d;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Score array, walk pointer, running best and held result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < N_CLASSES; c++) begin
            score_q[c] <= '0;
         end
         idx_q       <= '0;
         best_idx_q  <= '0;
         best_q      <= '0;
         res_idx_q   <= '0;
         res_score_q <= '0;
         run_q       <= 1'b0;
      end else begin
         for (int c = 0; c < N_CLASSES; c++) begin
            score_q[c] <= score_d[c];
         end
         idx_q       <= idx_d;
         best_idx_q  <= best_idx_d;
         best_q      <= best_d;
         res_idx_q   <= res_idx_d;
         res_score_q <= res_score_d;
         run_q       <= run_d;
      end
   end

   assign class_o = res_idx_q;
   assign score_o = res_score_q;

endmodule

// File: rtl/bnn_infer_ctrl.sv
// Sequencer around the combinational BNN datapath: loads a byte-streamed
// image, holds it on the BNN input, waits SETTLE_CYCLES for the multicycle
// path, captures the class scores, and reports the argmax with a done pulse.
// Optional macro BNN_TRIGGER_EN adds trigger_o. trigger_o is high from the
// first settle cycle through the capture cycle, for side-channel capture.
module bnn_infer_ctrl
   import bnn_ctrl_pkg::*;
#(
   parameter int IMG_BITS      = DEF_IMG_BITS,
   parameter int BYTE_W        = DEF_BYTE_W,
   parameter int N_CLASSES     = DEF_N_CLASSES,
   parameter int SCORE_W       = DEF_SCORE_W,
   parameter int CLASS_W       = DEF_CLASS_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [BYTE_W-1:0]            img_data_i,
   input  logic                         img_valid_i,
   output logic                         img_ready_o,
   output logic [IMG_BITS-1:0]          bnn_layer_o,
   input  logic [N_CLASSES*SCORE_W-1:0] bnn_scores_i,
   output logic                         busy_o,
   output logic                         done_o,
`ifdef BNN_TRIGGER_EN
   output logic                         trigger_o,
`endif
   output logic [CLASS_W-1:0]           class_o,
   output logic [SCORE_W-1:0]           score_o
);

   localparam int N_BYTES = IMG_BITS / BYTE_W;
   localparam int BCNT_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   ctrl_state_t         state_q, state_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [IMG_BITS-1:0] layer_q, layer_d;
   logic                argmax_start;
   logic                argmax_done;

   // Next-state logic: image loading, settle countdown and argmax hand-off
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      settle_cnt_d = settle_cnt_q;
      layer_d      = layer_q;
      argmax_start = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               byte_cnt_d = '0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (img_valid_i) begin
               layer_d[int'(byte_cnt_q)*BYTE_W +: BYTE_W] = img_data_i;
               if (byte_cnt_q == BCNT_W'(N_BYTES-1)) begin
                  byte_cnt_d   = '0;
                  settle_cnt_d = SETTLE_W'(SETTLE_CYCLES);
                  state_d      = ST_SETTLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_W'(1)) begin
               settle_cnt_d = '0;
               state_d      = ST_CAPTURE;
            end else begin
               settle_cnt_d = settle_cnt_q - 1'b1;
            end
         end
         ST_CAPTURE: begin
            argmax_start = 1'b1;
            state_d      = ST_ARGMAX;
         end
         ST_ARGMAX: begin
            if (argmax_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and the image register that drives the BNN input
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         settle_cnt_q <= '0;
         layer_q      <= '0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         layer_q      <= layer_d;
      end
   end

   bnn_argmax_seq #(
      .N_CLASSES (N_CLASSES),
      .SCORE_W   (SCORE_W),
      .CLASS_W   (CLASS_W)
   ) u_argmax (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (argmax_start),
      .scores_i  (bnn_scores_i),
      .done_o    (argmax_done),
      .class_o   (class_o),
      .score_o   (score_o)
   );

   assign img_ready_o = (state_q == ST_LOAD);
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign bnn_layer_o = layer_q;

`ifdef BNN_TRIGGER_EN
   assign trigger_o = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
`endif

endmodule

// File: doc/bnn_infer_ctrl.md
Name: bnn_infer_ctrl

Overview:
Sequencer wrapped around the fully combinational BNN datapath.
- Accepts a 28x28 binary image as a byte stream and holds it stable on the BNN input.
- Waits a programmed number of settle cycles (multicycle path through the datapath), then registers the 10 class scores.
- Runs a sequential argmax over the registered scores and reports the winning class with a done pulse.
- Weights and thresholds are static and are not handled by this block.

Parameters:
IMG_BITS, 784, image bits (28x28x1); must be a multiple of BYTE_W
BYTE_W, 8, width of the input stream word
N_CLASSES, 10, number of output classes
SCORE_W, 7, width of each class score (unsigned)
CLASS_W, 4, width of the class index; must satisfy 2**CLASS_W >= N_CLASSES
SETTLE_CYCLES, 16, cycles allowed for the datapath to settle; legal range 1..255

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  begin a new inference; honoured only in IDLE
img_data_i  in  BYTE_W  image byte
img_valid_i  in  1  image byte valid
img_ready_o  out  1  block accepts an image byte
bnn_layer_o  out  IMG_BITS  registered image driving the BNN input (flat index = row*28+col)
bnn_scores_i  in  N_CLASSES*SCORE_W  BNN class scores; class c occupies bits [c*SCORE_W +: SCORE_W]
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when the result is valid
class_o  out  CLASS_W  winning class index, held until the next done_o
score_o  out  SCORE_W  winning score, held until the next done_o

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: state IDLE; img_ready_o=0, busy_o=0, done_o=0, class_o=0, score_o=0, bnn_layer_o=0; all counters 0.
- States: IDLE, LOAD, SETTLE, CAPTURE, ARGMAX, DONE.
- IDLE:
  - start_i=1 clears the byte counter and moves to LOAD.
  - bnn_layer_o keeps the previous image, so the BNN input never glitches between runs.
- LOAD:
  - img_ready_o=1.
  - A byte is accepted when img_valid_i & img_ready_o.
  - Byte n writes bnn_layer_o[n*BYTE_W +: BYTE_W]; byte bit b maps to image bit n*BYTE_W+b.
  - Gaps in img_valid_i are allowed; the counter holds during gaps.
  - After byte IMG_BITS/BYTE_W-1 (98th byte at defaults) is accepted: img_ready_o=0 on the next cycle and the state moves to SETTLE.
- SETTLE:
  - Down-counter loaded with SETTLE_CYCLES; the block stays exactly SETTLE_CYCLES cycles.
  - No register feeding the BNN may change in this state.
- CAPTURE:
  - One cycle; registers bnn_scores_i into an internal score array.
  - Initialises best index = 0 and best score = score[0].
- ARGMAX:
  - One class per cycle, c = 1..N_CLASSES-1, giving N_CLASSES-1 cycles.
  - Best is replaced only if score[c] > best (strict), so ties resolve to the lowest index.
- DONE:
  - One cycle; done_o=1; class_o and score_o are updated at this edge.
  - Then returns to IDLE.
- Latency: last byte accepted at cycle t gives done_o at cycle t+SETTLE_CYCLES+N_CLASSES+1, i.e. t+27 at defaults.
- start_i is ignored while busy_o=1; start_i asserted in the DONE cycle is also ignored.
- img_valid_i outside LOAD is ignored and no byte is consumed.
- rst_i mid-operation: returns to IDLE on that edge with all reset values, including bnn_layer_o=0. A partially loaded image is discarded.
- Scores are unsigned; no arithmetic beyond compare, so no overflow handling is needed.

Optional Feature:
Macro BNN_TRIGGER_EN.
- Defined: adds output trigger_o (1 bit, reset 0) for side-channel capture.
  - trigger_o=1 from the first SETTLE cycle through the CAPTURE cycle inclusive (SETTLE_CYCLES+1 cycles); 0 otherwise.
  - Cleared immediately by rst_i.
- Undefined: no trigger_o port and no associated logic; all other behaviour is identical.

Decomposition:
- Package bnn_ctrl_pkg holds:
  - state enum ctrl_state_t;
  - localparams N_IMG_BYTES = IMG_BITS/BYTE_W and SETTLE_W = 8;
  - typedef score_t = logic [SCORE_W-1:0].
- One sub-module, bnn_argmax_seq: sequential argmax over a registered score array with start/done. The FSM, loader and settle counter stay in bnn_infer_ctrl.

Test Plan:
1. Reset values: assert rst_i for 3 cycles -> all outputs 0, busy_o=0. Pulse start_i -> busy_o=1 and img_ready_o=1 on the next cycle.
2. Full run: stream 98 bytes where byte n = n, with the BNN stub driving scores {c*5}, c=0..9 -> bnn_layer_o[15:8]=8'h01; done_o exactly 27 cycles after the last accept; class_o=9; score_o=45.
3. Ties and gaps: scores all 7'd20 except classes 3 and 7 = 7'd60; img_valid_i toggles every other cycle -> class_o=3, score_o=60; exactly 98 bytes consumed.
4. start_i pulsed during SETTLE and again in the DONE cycle -> both ignored; a single done_o; state returns to IDLE.
5. rst_i asserted after 40 bytes -> next cycle IDLE, bnn_layer_o=0, img_ready_o=0. A fresh run afterwards completes correctly.
6. With BNN_TRIGGER_EN defined and SETTLE_CYCLES=4 -> trigger_o high for exactly 5 cycles, aligned to SETTLE+CAPTURE. With the macro undefined, the port is absent and the design still compiles.
